// File: rtl/au_div_seq_if.sv
// Request/result bundle for the sequential sign-magnitude divider.
// The bench drives through master; the divider uses slave.
interface au_div_seq_if #(
  parameter int W = 24
);
  logic         start;
  logic         op_mode;
  logic [W-1:0] R_in;
  logic [W-1:0] S_in;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic         dz;
  logic         ovf;

  modport master (
    output start, op_mode, R_in, S_in,
    input  result, done, busy, dz, ovf
  );

  modport slave (
    input  start, op_mode, R_in, S_in,
    output result, done, busy, dz, ovf
  );
endinterface

// File: rtl/au_div_seq.sv
// Sequential radix-2 restoring divider/reciprocal on sign-magnitude
// fixed point; one quotient bit per cycle, saturating on overflow.
module au_div_seq #(
  parameter int W    = 24,
  parameter int FRAC = 14
) (
  input logic       clk,
  input logic       rst,
  au_div_seq_if.slave bus
);
  localparam int M  = W - 1 + FRAC;
  localparam int CW = $clog2(M + 1);
  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};
  localparam logic [M-1:0] RECIP_N = ONE << (2 * FRAC);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } st_t;

  st_t           r_st;
  st_t           w_nst;
  logic [M-1:0]  r_num;
  logic [M-1:0]  r_quo;
  logic [W-1:0]  r_rem;
  logic [W-2:0]  r_div;
  logic          r_sgn;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_result;
  logic          r_dz;
  logic          r_ovf;

  logic [W-2:0]  w_rmag;
  logic [W-2:0]  w_smag;
  logic          w_sz;
  logic [M-1:0]  w_nmag;
  logic          w_nsgn;
  logic          w_dzsgn;
  logic          w_start;
  logic          w_last;
  logic [W-1:0]  w_sh;
  logic          w_ge;
  logic [W-1:0]  w_rem_n;
  logic [M-1:0]  w_quo_n;
  logic          w_ovf;
  logic [W-2:0]  w_mag;
  logic          w_qsgn;
  logic          w_busy;
  logic          w_done;

  assign w_rmag  = bus.R_in[W-2:0];
  assign w_smag  = bus.S_in[W-2:0];
  assign w_sz    = (w_smag == '0);
  assign w_nmag  = bus.op_mode ? RECIP_N
                 : ({{FRAC{1'b0}}, w_rmag} << FRAC);
  assign w_nsgn  = bus.op_mode ? bus.S_in[W-1]
                 : (bus.R_in[W-1] ^ bus.S_in[W-1]);
  assign w_dzsgn = bus.op_mode ? bus.S_in[W-1]
                 : bus.R_in[W-1];
  assign w_start = (r_st == IDLE) && bus.start;
  assign w_last  = (r_st == CALC) && (r_cnt == CW'(M - 1));

  // Restoring step: shift in next numerator bit, subtract if it fits.
  assign w_sh    = {r_rem[W-2:0], r_num[M-1]};
  assign w_ge    = (w_sh >= {1'b0, r_div});
  assign w_rem_n = w_ge ? (w_sh - {1'b0, r_div}) : w_sh;
  assign w_quo_n = {r_quo[M-2:0], w_ge};

  assign w_ovf  = |w_quo_n[M-1:W-1];
  assign w_mag  = w_ovf ? '1 : w_quo_n[W-2:0];
  assign w_qsgn = r_sgn & (|w_mag);

  always_ff @(posedge clk) begin
    if (rst) r_st <= IDLE;
    else     r_st <= w_nst;
  end

  always_comb begin
    w_nst = r_st;
    unique case (r_st)
      IDLE: if (bus.start) w_nst = w_sz ? FIN : CALC;
      CALC: if (w_last) w_nst = FIN;
      FIN:  w_nst = IDLE;
      default: w_nst = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_st)
      IDLE: w_busy = 1'b0;
      CALC: w_busy = 1'b1;
      FIN: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_sgn    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_start) begin
      r_num <= w_nmag;
      r_quo <= '0;
      r_rem <= '0;
      r_div <= w_smag;
      r_sgn <= w_nsgn;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_dz  <= w_sz;
      // Zero divisor skips CALC: result lands on the accepting edge.
      if (w_sz) r_result <= {w_dzsgn, {(W-1){1'b1}}};
    end else if (r_st == CALC) begin
      r_num <= r_num << 1;
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_result <= {w_qsgn, w_mag};
        r_ovf    <= w_ovf;
      end
    end
  end

  assign bus.result = r_result;
  assign bus.done   = w_done;
  assign bus.busy   = w_busy;
  assign bus.dz     = r_dz;
  assign bus.ovf    = r_ovf;
endmodule
